// File: rtl/main_ctr_fsm_pkg.sv
// Shared encodings for the multicycle main controller: state codes, opcodes,
// ALU requests and the decoded strobe bundle.
package main_ctr_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StImmEx  = 4'd10,
        StImmWb  = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/main_ctr_fsm_if.sv
// Datapath-facing bundle of the main controller: opcode/handshake in, strobes out.
interface main_ctr_fsm_if;
    logic [5:0] opCode;
    logic       memReady;
    logic [1:0] aluOp;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [3:0] state;
    logic       illegalOp;

    modport master (
        output opCode, memReady,
        input  aluOp, pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg,
        input  irWrite, regWrite, regDst, aluSrcA, aluSrcB, pcSource, state, illegalOp
    );

    modport slave (
        input  opCode, memReady,
        output aluOp, pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg,
        output irWrite, regWrite, regDst, aluSrcA, aluSrcB, pcSource, state, illegalOp
    );
endinterface

// File: rtl/main_ctr_dec.sv
// Combinational state->strobe decode for the main controller.
// IMMEX/IMMWB strobes exist only when MAIN_CTR_ADDI_EN is defined.
module main_ctr_dec
    import main_ctr_fsm_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            StFetch: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                o_ctrl.alu_op    = AluAdd;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            StDecode: begin
                o_ctrl.alu_src_b = 2'b11;
                o_ctrl.alu_op    = AluAdd;
            end
            StMemAdr: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = AluAdd;
            end
            StMemRd: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ior_d    = 1'b1;
            end
            StMemWb: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                // Strobe only in the completing cycle so a stalled write fires once.
                o_ctrl.mem_write = i_mem_ready;
                o_ctrl.ior_d     = 1'b1;
            end
            StExec: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = AluFunct;
            end
            StAluWb: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            StBranch: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = AluSub;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 2'b01;
            end
            StJump: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = 2'b10;
            end
`ifdef MAIN_CTR_ADDI_EN
            StImmEx: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = AluAdd;
            end
            StImmWb: begin
                o_ctrl.reg_write = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_ctr_fsm.sv
// Multicycle MIPS-style main controller: state register, opcode latch and next-state logic.
// Define MAIN_CTR_ADDI_EN to support addi through IMMEX/IMMWB; otherwise addi is illegal.
module main_ctr_fsm
    import main_ctr_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    main_ctr_fsm_if.slave     bus
);

    state_e     r_state;
    state_e     w_state_next;
    logic [5:0] r_opcode;
    logic       r_illegal;
    logic       w_illegal_next;
    ctrl_t      w_ctrl;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= StFetch;
            r_opcode  <= 6'b000000;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_illegal <= w_illegal_next;
            if (r_state == StDecode) begin
                r_opcode <= bus.opCode;
            end
        end
    end

    always_comb begin
        w_state_next   = StFetch;
        w_illegal_next = 1'b0;
        case (r_state)
            StFetch:  w_state_next = bus.memReady ? StDecode : StFetch;
            StDecode: begin
                case (bus.opCode)
                    OpLw, OpSw: w_state_next = StMemAdr;
                    OpRtype:    w_state_next = StExec;
                    OpBeq:      w_state_next = StBranch;
                    OpJ:        w_state_next = StJump;
`ifdef MAIN_CTR_ADDI_EN
                    OpAddi:     w_state_next = StImmEx;
`endif
                    default:    w_illegal_next = 1'b1;
                endcase
            end
            // Uses the latched opcode; the live input may already hold the next instruction.
            StMemAdr: w_state_next = (r_opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  w_state_next = bus.memReady ? StMemWb : StMemRd;
            StMemWr:  w_state_next = bus.memReady ? StFetch : StMemWr;
            StExec:   w_state_next = StAluWb;
            StBranch: w_state_next = StFetch;
            StJump:   w_state_next = StFetch;
`ifdef MAIN_CTR_ADDI_EN
            StImmEx:  w_state_next = StImmWb;
`endif
            default:  w_state_next = StFetch;
        endcase
    end

    main_ctr_dec u_dec (
        .i_state     (r_state),
        .i_mem_ready (bus.memReady),
        .o_ctrl      (w_ctrl)
    );

    assign bus.aluOp       = w_ctrl.alu_op;
    assign bus.pcWrite     = w_ctrl.pc_write;
    assign bus.pcWriteCond = w_ctrl.pc_write_cond;
    assign bus.iorD        = w_ctrl.ior_d;
    assign bus.memRead     = w_ctrl.mem_read;
    assign bus.memWrite    = w_ctrl.mem_write;
    assign bus.memToReg    = w_ctrl.mem_to_reg;
    assign bus.irWrite     = w_ctrl.ir_write;
    assign bus.regWrite    = w_ctrl.reg_write;
    assign bus.regDst      = w_ctrl.reg_dst;
    assign bus.aluSrcA     = w_ctrl.alu_src_a;
    assign bus.aluSrcB     = w_ctrl.alu_src_b;
    assign bus.pcSource    = w_ctrl.pc_source;
    assign bus.state       = r_state;
    assign bus.illegalOp   = r_illegal;

endmodule
